// File: rtl/imem_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory responder.
package imem_pkg;

    localparam int          WORD_BYTES   = 4;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

// File: rtl/imem_array.sv
// Word storage with one synchronous load port and one registered read port.
module imem_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Reading the array before this edge's write lands gives the old word on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts one request, waits LATENCY cycles, returns the word or an error.
module imem_responder
    import imem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DEFAULT_BASE),
    parameter int                LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [DATA_W-1:0]     ld_data
);

    localparam int         WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int         WOFF_W     = ADDR_W - WORD_SHIFT;
    localparam logic [3:0] CNT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                  state;
    logic [3:0]              count;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       cur_addr;
    logic [WOFF_W-1:0]       word_off;
    logic                    addr_err;
    logic                    enter_resp;
    logic                    rd_en;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DATA_W-1:0]       rd_data;
    logic                    err_q;

    // BASE is word aligned, so the offset is formed on word addresses; a wrap below BASE lands out of range.
    always_comb begin
        cur_addr   = (state == IDLE) ? req_addr : addr_q;
        word_off   = cur_addr[ADDR_W-1:WORD_SHIFT] - BASE[ADDR_W-1:WORD_SHIFT];
        addr_err   = (cur_addr[WORD_SHIFT-1:0] != '0) || (word_off[WOFF_W-1:DEPTH_LOG2] != '0);
        rd_idx     = word_off[DEPTH_LOG2-1:0];
        enter_resp = 1'b0;
        if (LATENCY == 0) begin
            enter_resp = (state == IDLE) && req_valid;
        end else begin
            enter_resp = (state == WAIT) && (count == 4'd0);
        end
        rd_en      = enter_resp && !addr_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= 4'd0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (enter_resp) begin
                err_q <= addr_err;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q;
    assign rsp_data  = err_q ? '0 : rd_data;

    imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W    (DATA_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (ld_en),
        .wr_idx (ld_idx),
        .wr_data(ld_data),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

endmodule
